// File: rtl/gx4000_cart_sdram_bridge.sv
// Cartridge-load write bridge: debounces the cart write strobe, queues writes in a
// small FIFO and issues them one at a time to the SDRAM controller over req/ack.
module gx4000_cart_sdram_bridge #(
  parameter int          DEPTH   = 8,
  parameter logic [24:0] BASE    = 25'h0400000,
  parameter int          TIMEOUT = 255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [24:0] cart_addr,
  input  logic [7:0]  cart_data,
  input  logic        cart_wr,
  input  logic        download,
  output logic        sdram_req,
  output logic [24:0] sdram_addr,
  output logic [7:0]  sdram_din,
  output logic        sdram_we,
  input  logic        sdram_ack,
  output logic        busy,
  output logic [15:0] byte_count,
  output logic        overflow,
  output logic        timeout_err
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
  localparam logic [15:0] TMO16 = 16'(TIMEOUT);

  typedef enum logic {IDLE, REQ} state_t;

  state_t        state;
  logic [24:0]   fifo_addr [DEPTH];
  logic [7:0]    fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          cart_wr_p0;
  logic          download_p0;
  logic [15:0]   wait_cnt;

  logic wr_edge;
  logic dl_rise;
  logic push;
  logic ack_hit;
  logic tmo_hit;
  logic pop;

  // Occupancy is sampled at the start of the cycle, so a same-cycle pop never frees room.
  assign wr_edge  = cart_wr & ~cart_wr_p0;
  assign dl_rise  = download & ~download_p0;
  assign push     = wr_edge && (count < FULL);
  assign ack_hit  = (state == REQ) && sdram_ack;
  assign tmo_hit  = (state == REQ) && !sdram_ack && (wait_cnt == TMO16);
  assign pop      = ack_hit || tmo_hit;
  assign sdram_we = sdram_req;

  // Storage stage: FIFO payload carries no reset.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cart_addr;
      fifo_data[wr_ptr] <= cart_data;
    end
  end

  // Control stage: pointers, FSM, status flags.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cart_wr_p0  <= 1'b0;
      download_p0 <= 1'b0;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      byte_count  <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      sdram_req   <= 1'b0;
      sdram_addr  <= BASE;
      sdram_din   <= '0;
    end else begin
      cart_wr_p0  <= cart_wr;
      download_p0 <= download;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      busy  <= (count != '0) || (state == REQ);

      case (state)
        IDLE: begin
          if (count != '0) begin
            sdram_addr <= BASE + fifo_addr[rd_ptr];
            sdram_din  <= fifo_data[rd_ptr];
            sdram_req  <= 1'b1;
            wait_cnt   <= 16'd1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (pop) begin
            sdram_req <= 1'b0;
            wait_cnt  <= '0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // A download restart clears the status and outranks any same-cycle update.
      if (dl_rise) begin
        byte_count  <= '0;
        overflow    <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        if (ack_hit)           byte_count  <= byte_count + 16'd1;
        if (wr_edge && !push)  overflow    <= 1'b1;
        if (tmo_hit)           timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/gx4000_cart_sdram_bridge.md
# gx4000_cart_sdram_bridge

Downstream stage of the Plus-mode top (`PlusMode`). It consumes the cartridge write stream (`cart_addr`/`cart_data`/`cart_wr`) produced while a cartridge image is loaded. It buffers the writes in a small FIFO, offsets each address into the cartridge region of SDRAM, and issues them one at a time to the SDRAM controller over a req/ack handshake. It also reports a byte count, an overflow flag and a timeout flag to the OSD/status logic.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `BASE`, 25'h0400000: SDRAM byte offset of the cartridge region.
- `TIMEOUT`, 255: maximum cycles to wait for `sdram_ack` per request; 1..65535.

Ports:
- `clk_sys` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `cart_addr` in 25: cartridge byte address.
- `cart_data` in 8: cartridge byte.
- `cart_wr` in 1: write strobe; may be held high for several cycles.
- `download` in 1: cartridge download in progress (level).
- `sdram_req` out 1: request valid.
- `sdram_addr` out 25: `BASE + cart_addr`, modulo 2^25.
- `sdram_din` out 8: write data.
- `sdram_we` out 1: always equals `sdram_req`; the bridge issues writes only.
- `sdram_ack` in 1: one-cycle completion pulse from the SDRAM controller.
- `busy` out 1: FIFO non-empty or a request is outstanding.
- `byte_count` out 16: writes retired with ack; wraps from FFFF to 0000.
- `overflow` out 1: sticky; a strobe was dropped because the FIFO was full.
- `timeout_err` out 1: sticky; a request was abandoned after `TIMEOUT` cycles.

## Operation
- **Strobe detection:**
  - A write is detected on any cycle where `cart_wr`=1 and the registered previous `cart_wr`=0 (rising edge).
  - A level held high for N cycles counts as one write.
- **FIFO push:**
  - A detected write pushes {addr, data} if the FIFO occupancy at the start of the cycle is less than `DEPTH`.
  - Otherwise the write is dropped and `overflow` is set.
  - A pop in the same cycle does not free space for that push.
- **FSM, two states:**
  - IDLE: `sdram_req`=0. If the FIFO is non-empty, latch the head entry into the output registers and go to REQ.
  - REQ: `sdram_req`=1, with address and data held stable.
    - `sdram_ack`=1: pop the entry, increment `byte_count`, go to IDLE.
    - Wait counter reaches `TIMEOUT` with no ack: pop and discard the entry, set `timeout_err`, go to IDLE.
  - `sdram_ack` arriving in IDLE is ignored.
- **Address arithmetic:** a 25-bit add with the carry discarded, so `BASE` + 1FFFFFF wraps around.
- **Rising edge of `download`:**
  - Clears `byte_count`, `overflow` and `timeout_err`.
  - Does not flush the FIFO or abort an outstanding request.
- **Simultaneous events:**
  - If the download rising edge and an ack occur in the same cycle, the clear wins and `byte_count`=0.
  - If a push occurs while the FIFO is empty and the FSM is in IDLE, the entry becomes visible to the FSM on the next cycle.
- **Reset:**
  - Empties the FIFO and forces IDLE.
  - Clears the wait counter, `byte_count`, `overflow` and `timeout_err`.
  - Clears the previous-`cart_wr` register.
  - Reset mid-request drops the outstanding write with no ack accounting.

## Timing
- **Reset values:** all outputs 0, except `sdram_addr`=BASE and `sdram_din`=0.
- **Latency:**
  - Edge detected in cycle N with the FIFO empty and the FSM in IDLE: entry stored at the end of N.
  - The FSM sees the entry in N+1 and latches it.
  - `sdram_req`=1 from cycle N+2.
- **Ack:** sampled on every cycle of REQ, including the first. After the ack cycle, `sdram_req`=0 for at least one cycle.
- **Throughput:** maximum one write per 2 cycles.
- **Timeout:** if no ack arrives, `sdram_req` stays high for exactly `TIMEOUT` cycles; `timeout_err`=1 and `sdram_req`=0 on the following cycle.
- **`busy`:** registered, and equal to (occupancy≠0 or state=REQ) as of the previous edge.
- **Status flags:** `overflow` and `timeout_err` are visible one cycle after the causing event.

## Test plan
- **Single write:** `cart_addr`=0x000010, `cart_data`=0xA5 pulsed 1 cycle, ack 3 cycles after req rises.
  - Required: `sdram_addr`=0x0400010, `sdram_din`=0xA5, req held for 4 cycles, `byte_count`=1, `busy` falls.
- **Held strobe:** `cart_wr` high for 10 cycles.
  - Required: exactly one SDRAM request; `byte_count`=1.
- **Overflow:** ack held at 0 with `TIMEOUT`=255; 10 single-cycle strobes spaced 2 cycles apart, data 0..9.
  - Required: 8 entries stored, `overflow`=1, writes 8 and 9 never issued.
  - Then ack every request: `byte_count`=8 with data 0..7 in order.
- **Timeout:** `TIMEOUT`=4, one write, no ack.
  - Required: req high for 4 cycles, then `timeout_err`=1, `byte_count`=0, FSM returns to IDLE.
  - The next write then completes normally.
- **Address wrap:** `BASE`=0x1FFFFF0, `cart_addr`=0x20.
  - Required: `sdram_addr`=0x0000010.
- **Reset mid-request:** with req=1 and 3 entries queued, `reset` pulsed for 1 cycle.
  - Required: next cycle req=0, `busy`=0, `byte_count`=0; a late `sdram_ack` has no effect.
